// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter for light-phase timing.
// Loads a preset on pulse, steps down once every TICK_DIV tick strobes,
// and emits a one-cycle done pulse on expiry, plus busy/warn status.
// Optional feature macro: COUNTDOWN_BCD_EN (registered BCD tens/units of
// count; without it tens/units are tied to zero).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no run in progress; ticks and hold ignored, count kept
// S_RUN    | counting down on tick strobes through the prescaler
// S_HOLD   | countdown frozen; prescaler retained until hold drops
// S_EXPIRE | single cycle with done=1, then back to idle

module countdown_timer #(
    parameter int WIDTH    = 6,
    parameter int TICK_DIV = 1,
    parameter int WARN     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse,
    input  logic [WIDTH-1:0] preset,
    input  logic             tick,
    input  logic             hold,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             warn,
    output logic [3:0]       tens,
    output logic [3:0]       units
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HOLD   = 2'd2,
        S_EXPIRE = 2'd3
    } state_t;

    // Prescaler is 8 bits because TICK_DIV is limited to 1..255.
    localparam logic [7:0]       PRE_LAST = 8'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] WARN_LVL = WIDTH'(WARN);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    state_t           state, state_nxt;
    logic [7:0]       prescale, prescale_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             busy_nxt, done_nxt, warn_nxt;

    // Next-state and next-output logic; pulse beats hold, hold beats tick.
    always_comb begin
        state_nxt    = state;
        prescale_nxt = prescale;
        count_nxt    = count;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        warn_nxt     = 1'b0;

        if (pulse) begin
            count_nxt    = preset;
            prescale_nxt = '0;
            if (preset == '0) begin
                state_nxt = S_EXPIRE;
            end else if (hold) begin
                state_nxt = S_HOLD;
            end else begin
                state_nxt = S_RUN;
            end
        end else begin
            unique case (state)
                S_RUN: begin
                    if (hold) begin
                        state_nxt = S_HOLD;
                    end else if (tick) begin
                        if (prescale == PRE_LAST) begin
                            prescale_nxt = '0;
                            // count is never 0 while running; guard keeps it from wrapping
                            if (count > ONE) begin
                                count_nxt = count - ONE;
                            end else begin
                                count_nxt = '0;
                                state_nxt = S_EXPIRE;
                            end
                        end else begin
                            prescale_nxt = prescale + 8'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!hold) begin
                        state_nxt = S_RUN;
                    end
                end
                S_EXPIRE: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end

        busy_nxt = (state_nxt == S_RUN) || (state_nxt == S_HOLD);
        done_nxt = (state_nxt == S_EXPIRE);
        warn_nxt = busy_nxt && (count_nxt <= WARN_LVL);
    end

    // State, prescaler and all status outputs registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            prescale <= '0;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            warn     <= 1'b0;
        end else begin
            state    <= state_nxt;
            prescale <= prescale_nxt;
            count    <= count_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            warn     <= warn_nxt;
        end
    end

`ifdef COUNTDOWN_BCD_EN
    logic [31:0] cnt_ext;
    logic [3:0]  tens_nxt, units_nxt;

    // Convert the upcoming count so the digits change on the same edge as count.
    always_comb begin
        cnt_ext   = 32'(count_nxt);
        tens_nxt  = 4'd9;
        units_nxt = 4'd9;
        if (cnt_ext <= 32'd99) begin
            tens_nxt  = 4'(cnt_ext / 32'd10);
            units_nxt = 4'(cnt_ext % 32'd10);
        end
    end

    // BCD digit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens  <= 4'd0;
            units <= 4'd0;
        end else begin
            tens  <= tens_nxt;
            units <= units_nxt;
        end
    end
`else
    assign tens  = 4'd0;
    assign units = 4'd0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer: directed scenarios on a default instance
// plus randomized traffic on two instances against a behavioural model.
module tb_countdown_timer;

    localparam int W_A = 6, DIV_A = 1, WARN_A = 3;
    localparam int W_B = 7, DIV_B = 3, WARN_B = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pulse = 1'b0, tick = 1'b0, hold = 1'b0;
    logic [W_A-1:0] preset_a = '0;
    logic [W_B-1:0] preset_b = '0;

    logic [W_A-1:0] count_a;
    logic           busy_a, done_a, warn_a;
    logic [3:0]     tens_a, units_a;
    logic [W_B-1:0] count_b;
    logic           busy_b, done_b, warn_b;
    logic [3:0]     tens_b, units_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int count;
        int pre;
        bit active;   // a run is in progress (counting or frozen)
        bit frozen;
        bit done;
    } mdl_t;

    mdl_t ma, mb;

    countdown_timer dut_a (
        .clk(clk), .rst_n(rst_n), .pulse(pulse), .preset(preset_a),
        .tick(tick), .hold(hold), .count(count_a), .busy(busy_a),
        .done(done_a), .warn(warn_a), .tens(tens_a), .units(units_a)
    );

    countdown_timer #(.WIDTH(W_B), .TICK_DIV(DIV_B), .WARN(WARN_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .pulse(pulse), .preset(preset_b),
        .tick(tick), .hold(hold), .count(count_b), .busy(busy_b),
        .done(done_b), .warn(warn_b), .tens(tens_b), .units(units_b)
    );

    always #5 clk = ~clk;

    function automatic mdl_t mdl_zero();
        mdl_t z;
        z.count = 0; z.pre = 0; z.active = 0; z.frozen = 0; z.done = 0;
        return z;
    endfunction

    // One clock of behaviour in terms of the timer's rules.
    function automatic mdl_t mdl_step(mdl_t m, bit p, int pv, bit h, bit t, int div);
        mdl_t n = m;
        n.done = 0;
        if (p) begin
            n.count  = pv;
            n.pre    = 0;
            n.active = (pv != 0);
            n.frozen = (pv != 0) && h;
            n.done   = (pv == 0);
        end else if (m.active) begin
            if (m.frozen) begin
                n.frozen = h;
            end else if (h) begin
                n.frozen = 1;
            end else if (t) begin
                if (m.pre + 1 == div) begin
                    n.pre   = 0;
                    n.count = (m.count > 0) ? m.count - 1 : 0;
                    if (n.count == 0) begin
                        n.active = 0;
                        n.frozen = 0;
                        n.done   = 1;
                    end
                end else begin
                    n.pre = m.pre + 1;
                end
            end
        end
        return n;
    endfunction

    function automatic int bcd_t(int c);
`ifdef COUNTDOWN_BCD_EN
        return (c > 99) ? 9 : c / 10;
`else
        return 0;
`endif
    endfunction

    function automatic int bcd_u(int c);
`ifdef COUNTDOWN_BCD_EN
        return (c > 99) ? 9 : c % 10;
`else
        return 0;
`endif
    endfunction

    // Drive one clock of inputs, then advance both models.
    task automatic cycle(input bit p, input int pa, input int pb, input bit h, input bit t);
        pulse    = p;
        preset_a = W_A'(pa);
        preset_b = W_B'(pb);
        hold     = h;
        tick     = t;
        @(posedge clk);
        #1;
        ma = mdl_step(ma, p, pa % (1 << W_A), h, t, DIV_A);
        mb = mdl_step(mb, p, pb % (1 << W_B), h, t, DIV_B);
        pulse = 1'b0;
        tick  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ma = mdl_zero();
        mb = mdl_zero();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({count_a, busy_a, done_a, warn_a, tens_a, units_a} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0",
                     {count_a, busy_a, done_a, warn_a, tens_a, units_a});
        end
        rst_n = 1'b1;
        ma = mdl_zero();
        mb = mdl_zero();
    endtask

    task automatic test_basic();
        logic [W_A+2:0] exp;
        cycle(1, 5, 5, 0, 0);
        checks++;
        if ({count_a, busy_a, done_a, warn_a} !== {6'd5, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_load got %h exp %h", {count_a, busy_a, done_a, warn_a},
                     {6'd5, 1'b1, 1'b0, 1'b0});
        end
        for (int i = 4; i >= 0; i--) begin
            cycle(0, 0, 0, 0, 1);
            exp = {W_A'(i), (i > 0), (i == 0), (i > 0 && i <= WARN_A)};
            checks++;
            if ({count_a, busy_a, done_a, warn_a} !== exp) begin
                errors++;
                $display("FAIL basic_step%0d got %h exp %h", i,
                         {count_a, busy_a, done_a, warn_a}, exp);
            end
        end
        cycle(0, 0, 0, 0, 1);
        checks++;
        if ({count_a, busy_a, done_a} !== {6'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_after_done got %h exp 0", {count_a, busy_a, done_a});
        end
    endtask

    task automatic test_hold();
        cycle(1, 30, 30, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 1, 1);
            checks++;
            if ({count_a, busy_a} !== {6'd30, 1'b1}) begin
                errors++;
                $display("FAIL hold_freeze%0d got %h exp %h", i, {count_a, busy_a}, {6'd30, 1'b1});
            end
        end
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        checks++;
        if ({count_a, busy_a, warn_a} !== {6'd28, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL hold_resume got %h exp %h", {count_a, busy_a, warn_a}, {6'd28, 1'b1, 1'b0});
        end
    endtask

    task automatic test_load_tick();
        cycle(1, 12, 12, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        checks++;
        if (count_a !== 6'd10) begin
            errors++;
            $display("FAIL loadtick_pre got %0d exp 10", count_a);
        end
        cycle(1, 22, 22, 0, 1);
        checks++;
        if ({count_a, busy_a} !== {6'd22, 1'b1}) begin
            errors++;
            $display("FAIL loadtick_load got %h exp %h", {count_a, busy_a}, {6'd22, 1'b1});
        end
        cycle(0, 0, 0, 0, 1);
        checks++;
        if (count_a !== 6'd21) begin
            errors++;
            $display("FAIL loadtick_next got %0d exp 21", count_a);
        end
    endtask

    task automatic test_zero_preset();
        cycle(1, 0, 0, 0, 0);
        checks++;
        if ({count_a, busy_a, done_a} !== {6'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL zero_done got %h exp %h", {count_a, busy_a, done_a}, {6'd0, 1'b0, 1'b1});
        end
        cycle(0, 0, 0, 0, 1);
        checks++;
        if ({count_a, busy_a, done_a} !== {6'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL zero_single got %h exp 0", {count_a, busy_a, done_a});
        end
        // load arriving while done is high
        cycle(1, 0, 0, 0, 0);
        cycle(1, 7, 7, 0, 0);
        checks++;
        if ({count_a, busy_a, done_a} !== {6'd7, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL expire_load got %h exp %h", {count_a, busy_a, done_a}, {6'd7, 1'b1, 1'b0});
        end
    endtask

    task automatic test_async_reset();
        cycle(1, 15, 15, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 1);
        checks++;
        if (count_a !== 6'd12) begin
            errors++;
            $display("FAIL areset_pre got %0d exp 12", count_a);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({count_a, busy_a, done_a, warn_a, tens_a, units_a} !== '0) begin
            errors++;
            $display("FAIL areset_clear got %h exp 0",
                     {count_a, busy_a, done_a, warn_a, tens_a, units_a});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ma = mdl_zero();
        mb = mdl_zero();
        repeat (4) cycle(0, 0, 0, 0, 1);
        checks++;
        if ({count_a, busy_a, done_a} !== '0) begin
            errors++;
            $display("FAIL areset_after got %h exp 0", {count_a, busy_a, done_a});
        end
    endtask

    task automatic test_bcd();
        logic [7:0] exp;
        cycle(1, 22, 22, 0, 0);
`ifdef COUNTDOWN_BCD_EN
        exp = 8'h22;
`else
        exp = 8'h00;
`endif
        checks++;
        if ({tens_a, units_a} !== exp) begin
            errors++;
            $display("FAIL bcd_22 got %h exp %h", {tens_a, units_a}, exp);
        end
        cycle(1, 47, 47, 0, 0);
`ifdef COUNTDOWN_BCD_EN
        exp = 8'h47;
`else
        exp = 8'h00;
`endif
        checks++;
        if ({tens_a, units_a} !== exp) begin
            errors++;
            $display("FAIL bcd_47 got %h exp %h", {tens_a, units_a}, exp);
        end
    endtask

    task automatic test_random();
        logic [W_A+9:0] got_a, exp_a;
        logic [W_B+9:0] got_b, exp_b;
        bit h = 0;
        bit p, t;
        int pa, pb;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            p  = ($urandom_range(0, 11) == 0);
            t  = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 7) == 0) h = ~h;
            pa = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
            pb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
            cycle(p, pa, pb, h, t);
            got_a = {count_a, busy_a, done_a, warn_a, tens_a, units_a};
            exp_a = {W_A'(ma.count), ma.active, ma.done,
                     (ma.active && ma.count <= WARN_A),
                     4'(bcd_t(ma.count)), 4'(bcd_u(ma.count))};
            checks++;
            if (got_a !== exp_a) begin
                errors++;
                $display("FAIL rand_a cycle %0d got %h exp %h", n, got_a, exp_a);
            end
            got_b = {count_b, busy_b, done_b, warn_b, tens_b, units_b};
            exp_b = {W_B'(mb.count), mb.active, mb.done,
                     (mb.active && mb.count <= WARN_B),
                     4'(bcd_t(mb.count)), 4'(bcd_u(mb.count))};
            checks++;
            if (got_b !== exp_b) begin
                errors++;
                $display("FAIL rand_b cycle %0d got %h exp %h", n, got_b, exp_b);
            end
        end
        hold = 1'b0;
    endtask

    initial begin
        ma = mdl_zero();
        mb = mdl_zero();
        test_reset();
        test_basic();
        test_hold();
        test_load_tick();
        test_zero_preset();
        test_async_reset();
        test_bcd();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
